// File: rtl/compare_event_monitor_pkg.sv
// Shared types and flag decode for compare_event_monitor.
// Relation codes match the comparator_four_bit flag semantics.
package cmp_mon_pkg;

  typedef enum logic [1:0] {
    REL_NONE = 2'd0,
    REL_GT   = 2'd1,
    REL_LT   = 2'd2,
    REL_EQ   = 2'd3
  } rel_t;

  // Priority decode GT > LT > EQ; no flag set yields REL_NONE.
  function automatic rel_t flags_to_rel(input logic gt, input logic lt, input logic eq);
    rel_t r;
    r = REL_NONE;
    if (eq) r = REL_EQ;
    if (lt) r = REL_LT;
    if (gt) r = REL_GT;
    return r;
  endfunction

  function automatic logic flags_onehot(input logic gt, input logic lt, input logic eq);
    return ({gt, lt, eq} == 3'b100) || ({gt, lt, eq} == 3'b010) || ({gt, lt, eq} == 3'b001);
  endfunction

endpackage

// File: rtl/compare_event_monitor_if.sv
// Flag/observation bundle between comparator_four_bit side and the monitor.
// master drives the flags and clear; slave is the monitor.
interface compare_event_monitor_if
  import cmp_mon_pkg::*;
#(
  parameter int CNT_W = 8
);
  logic             flag_valid;
  logic             greater_than;
  logic             less_than;
  logic             equal;
  logic             clr_counts;
  rel_t             stable_rel;
  logic             change_pulse;
  logic [CNT_W-1:0] gt_count;
  logic [CNT_W-1:0] lt_count;
  logic [CNT_W-1:0] eq_count;
  logic [CNT_W-1:0] trans_count;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;

  modport master (
    output flag_valid, greater_than, less_than, equal, clr_counts,
    input  stable_rel, change_pulse, gt_count, lt_count, eq_count,
           trans_count, err_sticky, err_count
  );

  modport slave (
    input  flag_valid, greater_than, less_than, equal, clr_counts,
    output stable_rel, change_pulse, gt_count, lt_count, eq_count,
           trans_count, err_sticky, err_count
  );
endinterface

// File: rtl/compare_event_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr)                 q <= '0;
    else if (inc && (q != {W{1'b1}})) q <= q + 1'b1;
  end
endmodule

// File: rtl/compare_event_monitor.sv
// Debounces comparator flags into a stable relation with change pulse and event counters.
// Define CMP_MON_ERR_EN to flag zero/multi-hot samples as errors instead of priority-decoding them.
module compare_event_monitor
  import cmp_mon_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = 3
) (
  input logic                    clk,
  input logic                    rst,
  compare_event_monitor_if.slave mon
);
  localparam int RUN_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] DEB = RUN_W'(DEBOUNCE);

  rel_t             rel;
  logic             legal;
  logic             illegal;
  rel_t             stable_rel;
  rel_t             cand;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;
  logic             change_pulse;
  logic             hit;

  always_comb begin
    rel = flags_to_rel(mon.greater_than, mon.less_than, mon.equal);
`ifdef CMP_MON_ERR_EN
    legal   = mon.flag_valid && flags_onehot(mon.greater_than, mon.less_than, mon.equal);
    illegal = mon.flag_valid && !legal;
`else
    legal   = mon.flag_valid && (rel != REL_NONE);
    illegal = 1'b0;
`endif
  end

  assign run_nxt = (rel == cand) ? run_cnt + 1'b1 : RUN_W'(1);
  assign hit     = legal && (rel != stable_rel) && (run_nxt == DEB);

  // stable_rel is the FSM state; it never returns to REL_NONE except through rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_rel   <= REL_NONE;
      cand         <= REL_NONE;
      run_cnt      <= '0;
      change_pulse <= 1'b0;
    end else begin
      change_pulse <= 1'b0;
      if (legal) begin
        if (rel == stable_rel) begin
          run_cnt <= '0;
        end else if (hit) begin
          stable_rel   <= rel;
          cand         <= rel;
          run_cnt      <= '0;
          change_pulse <= 1'b1;
        end else begin
          cand    <= rel;
          run_cnt <= run_nxt;
        end
      end
    end
  end

  logic [CNT_W-1:0] gt_q, lt_q, eq_q, trans_q;

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst(rst), .inc(legal && (rel == REL_GT)), .clr(mon.clr_counts), .q(gt_q));
  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst(rst), .inc(legal && (rel == REL_LT)), .clr(mon.clr_counts), .q(lt_q));
  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst(rst), .inc(legal && (rel == REL_EQ)), .clr(mon.clr_counts), .q(eq_q));
  sat_counter #(.W(CNT_W)) u_trans_cnt (
    .clk(clk), .rst(rst), .inc(hit), .clr(mon.clr_counts), .q(trans_q));

`ifdef CMP_MON_ERR_EN
  logic             err_sticky;
  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (rst || mon.clr_counts) err_sticky <= 1'b0;
    else if (illegal)          err_sticky <= 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .inc(illegal), .clr(mon.clr_counts), .q(err_q));

  assign mon.err_sticky = err_sticky;
  assign mon.err_count  = err_q;
`else
  assign mon.err_sticky = 1'b0;
  assign mon.err_count  = '0;
`endif

  assign mon.stable_rel   = stable_rel;
  assign mon.change_pulse = change_pulse;
  assign mon.gt_count     = gt_q;
  assign mon.lt_count     = lt_q;
  assign mon.eq_count     = eq_q;
  assign mon.trans_count  = trans_q;

endmodule

// File: tb/tb_compare_event_monitor.sv
// Table-driven bench for compare_event_monitor (DEBOUNCE=3, CNT_W=4), scoreboard of expected outputs.
module tb_compare_event_monitor;
  import cmp_mon_pkg::*;

`ifdef CMP_MON_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  compare_event_monitor_if #(.CNT_W(4)) bus();

  compare_event_monitor #(.CNT_W(4), .DEBOUNCE(3)) dut (
    .clk(clk),
    .rst(rst),
    .mon(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int r, v, g, l, e, c;
    int rel, p, gc, lc, ec, tc, errc, errs;
  } vec_t;

  typedef struct {
    int rel, p, gc, lc, ec, tc, errc, errs;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(int r, int v, int g, int l, int e, int c,
                              int rel, int p, int gc, int lc, int ec, int tc,
                              int errc, int errs);
    vec_t t;
    t.r = r; t.v = v; t.g = g; t.l = l; t.e = e; t.c = c;
    t.rel = rel; t.p = p; t.gc = gc; t.lc = lc; t.ec = ec; t.tc = tc;
    t.errc = errc; t.errs = errs;
    return t;
  endfunction

  // Reference comparator_four_bit: flags for a vs b.
  function automatic vec_t cmpv(int a, int b, vec_t t);
    vec_t o;
    o = t;
    o.g = (a > b) ? 1 : 0;
    o.l = (a < b) ? 1 : 0;
    o.e = (a == b) ? 1 : 0;
    return o;
  endfunction

  task automatic chk(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic step(vec_t t, int idx);
    exp_t x;
    rst              = t.r[0];
    bus.flag_valid   = t.v[0];
    bus.greater_than = t.g[0];
    bus.less_than    = t.l[0];
    bus.equal        = t.e[0];
    bus.clr_counts   = t.c[0];
    x.rel = t.rel; x.p = t.p; x.gc = t.gc; x.lc = t.lc; x.ec = t.ec;
    x.tc = t.tc; x.errc = t.errc; x.errs = t.errs;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("sb_empty[%0d]", idx), 0, 1);
    end else begin
      x = sb.pop_front();
      chk($sformatf("stable_rel[%0d]", idx),   int'(bus.stable_rel),   x.rel);
      chk($sformatf("change_pulse[%0d]", idx), int'(bus.change_pulse), x.p);
      chk($sformatf("gt_count[%0d]", idx),     int'(bus.gt_count),     x.gc);
      chk($sformatf("lt_count[%0d]", idx),     int'(bus.lt_count),     x.lc);
      chk($sformatf("eq_count[%0d]", idx),     int'(bus.eq_count),     x.ec);
      chk($sformatf("trans_count[%0d]", idx),  int'(bus.trans_count),  x.tc);
      chk($sformatf("err_count[%0d]", idx),    int'(bus.err_count),    x.errc);
      chk($sformatf("err_sticky[%0d]", idx),   int'(bus.err_sticky),   x.errs);
    end
  endtask

  initial begin
    vec_t t;
    int e1;
    rst = 1'b1;
    bus.flag_valid = 1'b0; bus.greater_than = 1'b0; bus.less_than = 1'b0;
    bus.equal = 1'b0; bus.clr_counts = 1'b0;
    e1 = ERR_EN;

    // Reset two cycles
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0, 0,0));
    // Three GT samples (9 vs 4) -> switch to GT on the third
    t = mk(0,1,0,0,0,0, 0,0,1,0,0,0, 0,0); vecs.push_back(cmpv(9,4,t));
    t = mk(0,1,0,0,0,0, 0,0,2,0,0,0, 0,0); vecs.push_back(cmpv(9,4,t));
    t = mk(0,1,0,0,0,0, 1,1,3,0,0,1, 0,0); vecs.push_back(cmpv(9,4,t));
    // Invalid sample holds everything
    vecs.push_back(mk(0,0,0,1,0,0, 1,0,3,0,0,1, 0,0));
    // LT,LT,GT,LT,LT -> no change; third consecutive LT switches
    t = mk(0,1,0,0,0,0, 1,0,3,1,0,1, 0,0); vecs.push_back(cmpv(2,7,t));
    t = mk(0,1,0,0,0,0, 1,0,3,2,0,1, 0,0); vecs.push_back(cmpv(2,7,t));
    t = mk(0,1,0,0,0,0, 1,0,4,2,0,1, 0,0); vecs.push_back(cmpv(15,0,t));
    t = mk(0,1,0,0,0,0, 1,0,4,3,0,1, 0,0); vecs.push_back(cmpv(0,15,t));
    t = mk(0,1,0,0,0,0, 1,0,4,4,0,1, 0,0); vecs.push_back(cmpv(0,15,t));
    t = mk(0,1,0,0,0,0, 2,1,4,5,0,2, 0,0); vecs.push_back(cmpv(3,8,t));
    // All-zero valid sample: ignored, or an error when checking is enabled
    vecs.push_back(mk(0,1,0,0,0,0, 2,0,4,5,0,2, e1,e1));
    // 20 EQ samples: eq_count saturates at 15, one change
    for (int k = 1; k <= 20; k++) begin
      t = mk(0,1,0,0,0,0, (k >= 3) ? 3 : 2, (k == 3) ? 1 : 0, 4, 5,
             (k > 15) ? 15 : k, (k >= 3) ? 3 : 2, e1, e1);
      vecs.push_back(cmpv(k % 16, k % 16, t));
    end
    // gt=lt=1: priority GT, or an error
    vecs.push_back(mk(0,1,1,1,0,0, 3,0,e1 ? 4 : 5,5,15,3, 2*e1,e1));
    vecs.push_back(mk(0,1,1,0,0,0, 3,0,e1 ? 5 : 6,5,15,3, 2*e1,e1));
    // clr with GT: counters clear; if the sample completes a change trans stays 0
    vecs.push_back(mk(0,1,1,0,0,1, e1 ? 3 : 1, e1 ? 0 : 1, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0, e1 ? 3 : 1, 0, 0,0,0,0, 0,0));
    // Mid-debounce reset: two LT, reset while LT presented, one LT must not switch
    vecs.push_back(mk(0,1,0,1,0,0, e1 ? 3 : 1, 0, 0,1,0,0, 0,0));
    vecs.push_back(mk(0,1,0,1,0,0, e1 ? 3 : 1, 0, 0,2,0,0, 0,0));
    vecs.push_back(mk(1,1,0,1,0,0, 0,0,0,0,0,0, 0,0));
    vecs.push_back(mk(0,1,0,1,0,0, 0,0,0,1,0,0, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,1,0,0, 0,0));
    vecs.push_back(mk(0,1,0,1,0,0, 0,0,0,2,0,0, 0,0));
    vecs.push_back(mk(0,1,0,1,0,0, 2,1,0,3,0,1, 0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 2,0,0,3,0,1, 0,0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
